out_bcd: RTL and testbench

SAP-1 output stage: consumes the accumulator value driven on the 8-bit bus when the controller asserts the load-output control bit. It holds the value in the OUT register and converts it to three BCD digits with a sequential double-dabble engine (one shift per clock). It also time-multiplexes the digits onto an active-low 3-digit 7-segment display. It sits directly downstream of the bus/accumulator and feeds the board-level binary and display outputs.

---
 rtl/out_bcd.sv | 166 ++++++++++++++++
 tb/tb_out_bcd.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_bcd.sv
// SAP-1 output stage: OUT register, sequential double-dabble binary-to-BCD
// converter (one shift per clock) and a 3-digit active-low 7-segment scanner.
// Optional feature macro: OUT_SIGNED_EN (two's-complement display with "-").
module out_bcd #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        ld_i,
  input  logic [7:0]  bus_i,
  output logic [7:0]  out_o,
  output logic [11:0] bcd_o,
  output logic        neg_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [6:0]  seg_o,
  output logic [2:0]  an_o
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(SCAN_DIV - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_t;

  state_t        state_q, state_d;
  logic [7:0]    out_q;
  logic [19:0]   sh_q;      // {bcd scratch[11:0], binary[7:0]}
  logic [2:0]    cnt_q;
  logic [11:0]   bcd_q;
  logic          neg_q;
  logic          valid_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    dig_q;

  logic [7:0]    mag;
  logic          sign;
  logic [19:0]   adj;
  logic [19:0]   sh_next;
  logic          last_shift;

  // Magnitude fed into the shifter and the sign latched with the result.
`ifdef OUT_SIGNED_EN
  assign mag  = bus_i[7] ? (~bus_i + 8'd1) : bus_i;
  assign sign = out_q[7];
`else
  assign mag  = bus_i;
  assign sign = 1'b0;
`endif

  // Double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  always_comb begin
    adj = sh_q;
    for (int i = 0; i < 3; i++) begin
      if (sh_q[8 + 4*i +: 4] >= 4'd5) begin
        adj[8 + 4*i +: 4] = sh_q[8 + 4*i +: 4] + 4'd3;
      end
    end
    sh_next = adj << 1;
  end

  assign last_shift = (state_q == StShift) && (cnt_q == 3'd7);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a load always (re)starts a conversion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ld_i) state_d = StShift;
      end
      StShift: begin
        if (ld_i) begin
          state_d = StShift;
        end else if (cnt_q == 3'd7) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: OUT register, shifter and result latch.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      out_q   <= 8'd0;
      sh_q    <= 20'd0;
      cnt_q   <= 3'd0;
      bcd_q   <= 12'd0;
      neg_q   <= 1'b0;
      valid_q <= 1'b1;
    end else if (ld_i) begin
      out_q   <= bus_i;
      sh_q    <= {12'd0, mag};
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else if (state_q == StShift) begin
      sh_q  <= sh_next;
      cnt_q <= cnt_q + 3'd1;
      if (last_shift) begin
        bcd_q   <= sh_next[19:8];
        neg_q   <= sign;
        valid_q <= 1'b1;
      end
    end
  end

  // Display scan: prescaler and digit index, free-running.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
      dig_q   <= 2'd0;
    end else if (presc_q == PrescLast) begin
      presc_q <= '0;
      dig_q   <= (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  logic [3:0] nib;

  // Output decode: digit select and 7-segment pattern, active-low.
  always_comb begin
    an_o = 3'b111;
    nib  = 4'd0;
    unique case (dig_q)
      2'd0: begin an_o = 3'b110; nib = bcd_q[3:0];  end
      2'd1: begin an_o = 3'b101; nib = bcd_q[7:4];  end
      2'd2: begin an_o = 3'b011; nib = bcd_q[11:8]; end
      default: begin an_o = 3'b111; nib = 4'hf; end
    endcase
    case (nib)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = 7'b1111111;
    endcase
`ifdef OUT_SIGNED_EN
    if ((dig_q == 2'd2) && neg_q && (bcd_q[11:8] == 4'd0)) begin
      seg_o = 7'b0111111;
    end
`endif
  end

  assign out_o   = out_q;
  assign bcd_o   = bcd_q;
  assign neg_o   = neg_q;
  assign busy_o  = (state_q == StShift);
  assign valid_o = valid_q;

endmodule

// File: tb/tb_out_bcd.sv
// Self-checking bench for out_bcd: behavioural model compared every cycle,
// plus directed literal checks from the test plan and randomized loads.
module tb_out_bcd;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rstn_i, ld_i;
  logic [7:0]  bus_i;
  logic [7:0]  out_o;
  logic [11:0] bcd_o;
  logic        neg_o, busy_o, valid_o;
  logic [6:0]  seg_o;
  logic [2:0]  an_o;

  int checks = 0;
  int errors = 0;

  out_bcd #(.SCAN_DIV(SCAN)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .ld_i    (ld_i),
    .bus_i   (bus_i),
    .out_o   (out_o),
    .bcd_o   (bcd_o),
    .neg_o   (neg_o),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .seg_o   (seg_o),
    .an_o    (an_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Behavioural model: result = decimal digits of |out| 8 edges after the last load.
  bit started = 0;
  int m_out, m_mag, m_neg, m_valid, m_pend, m_k;

  always @(posedge clk) begin
    if (!rstn_i) begin
      started = 1;
      m_out = 0; m_mag = 0; m_neg = 0; m_valid = 1; m_pend = -1; m_k = 0;
    end else if (started) begin
      m_k++;
      if (ld_i) begin
        m_out = bus_i; m_valid = 0; m_pend = 0;
      end else if (m_pend >= 0) begin
        m_pend++;
        if (m_pend == 8) begin
`ifdef OUT_SIGNED_EN
          m_neg = (m_out >= 128) ? 1 : 0;
          m_mag = (m_out >= 128) ? 256 - m_out : m_out;
`else
          m_neg = 0;
          m_mag = m_out;
`endif
          m_valid = 1;
          m_pend = -1;
        end
      end
    end
  end

  always @(posedge clk) begin
    int h, t, o, slot, exp_seg;
    #1;
    if (started) begin
      h = m_mag / 100; t = (m_mag / 10) % 10; o = m_mag % 10;
      slot = (m_k / SCAN) % 3;
      exp_seg = seg_of(slot == 0 ? o : (slot == 1 ? t : h));
`ifdef OUT_SIGNED_EN
      if (slot == 2 && m_neg == 1 && h == 0) exp_seg = 7'b0111111;
`endif
      check("out", out_o, m_out);
      check("bcd", bcd_o, h * 256 + t * 16 + o);
      check("neg", neg_o, m_neg);
      check("busy", busy_o, (m_pend >= 0) ? 1 : 0);
      check("valid", valid_o, m_valid);
      check("an", an_o, 7 & ~(1 << slot));
      check("seg", seg_o, exp_seg);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    ld_i = 1'b1; bus_i = v;
    @(negedge clk);
    ld_i = 1'b0; bus_i = $urandom_range(0, 255);
  endtask

  task automatic wait_an(input logic [2:0] want);
    for (int i = 0; i < 40; i++) begin
      if (an_o == want) break;
      @(negedge clk);
    end
    check("an_wait", an_o, want);
  endtask

  initial begin
    rstn_i = 1'b0; ld_i = 1'b0; bus_i = 8'h00;
    tick(2);
    rstn_i = 1'b1;
    tick(1);
    check("rst_out", out_o, 8'h00);
    check("rst_valid", valid_o, 1);
    check("rst_an", an_o, 3'b110);
    check("rst_seg", seg_o, 7'b1000000);

    // 0xFF: busy for 8 edges, then the result
    load(8'hFF);
    check("ff_out", out_o, 8'hFF);
    check("ff_busy0", busy_o, 1);
    tick(7);
    check("ff_busy7", busy_o, 1);
    check("ff_valid7", valid_o, 0);
    tick(1);
`ifdef OUT_SIGNED_EN
    check("ff_bcd", bcd_o, 12'h001);
    check("ff_neg", neg_o, 1);
`else
    check("ff_bcd", bcd_o, 12'h255);
    check("ff_neg", neg_o, 0);
`endif
    check("ff_valid", valid_o, 1);
    check("ff_busy", busy_o, 0);

    // 0x2A then restart with 0x07 at N+4
    load(8'h2A);
    tick(8);
    check("2a_bcd", bcd_o, 12'h042);
    load(8'h2A);
    tick(3);
    load(8'h07);
    check("07_out", out_o, 8'h07);
    check("07_hold", bcd_o, 12'h042);
    tick(7);
    check("07_hold11", bcd_o, 12'h042);
    check("07_valid11", valid_o, 0);
    tick(1);
    check("07_bcd", bcd_o, 12'h007);
    check("07_valid", valid_o, 1);

    // Reset mid-conversion
    load(8'h99);
    tick(2);
    rstn_i = 1'b0;
    tick(1);
    rstn_i = 1'b1;
    check("rst3_out", out_o, 0);
    check("rst3_bcd", bcd_o, 0);
    check("rst3_busy", busy_o, 0);
    check("rst3_valid", valid_o, 1);
    tick(10);
    check("rst3_stale", bcd_o, 0);

    // Scan of 123
    load(8'd123);
    tick(8);
    wait_an(3'b110);
    check("scan_ones", seg_o, 7'b0110000);
    tick(SCAN);
    check("scan_an1", an_o, 3'b101);
    check("scan_tens", seg_o, 7'b0100100);
    tick(SCAN);
    check("scan_an2", an_o, 3'b011);
    check("scan_hund", seg_o, 7'b1111001);

`ifdef OUT_SIGNED_EN
    load(8'h80);
    tick(8);
    check("s80_bcd", bcd_o, 12'h128);
    check("s80_neg", neg_o, 1);
    load(8'hF6);
    tick(8);
    check("sf6_bcd", bcd_o, 12'h010);
    check("sf6_neg", neg_o, 1);
    wait_an(3'b011);
    check("sf6_minus", seg_o, 7'b0111111);
`else
    load(8'hF6);
    tick(8);
    check("uf6_bcd", bcd_o, 12'h246);
    check("uf6_neg", neg_o, 0);
`endif

    // Randomized loads with occasional resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rstn_i = ($urandom_range(0, 99) != 0);
      ld_i   = ($urandom_range(0, 11) == 0);
      bus_i  = $urandom_range(0, 255);
    end
    @(negedge clk);
    rstn_i = 1'b1; ld_i = 1'b0;
    tick(12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
